rf_commit_sched: RTL and testbench

Commit-side scheduler for the register file's single write port. It accepts up to two in-order commits per cycle from the ROB and buffers them in a small FIFO. It drains them one per cycle into the register file. It also sequences exception flushes so the flush reaches the register file only after every older committed write. A bypass lookup lets the decoder see values still in flight.

---
 rtl/rf_commit_sched_if.sv | 45 ++++
 rtl/rf_commit_sched.sv | 173 +++++++++++++++++
 tb/tb_rf_commit_sched.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_commit_sched_if.sv
// Commit-path bundle for rf_commit_sched: ROB commit slots, register-file
// write port, exception flush and decoder bypass lookup.
// master: ROB/decoder side. slave: the scheduler.
interface rf_commit_sched_if #(
    parameter int unsigned RdLength   = 4,
    parameter int unsigned PcLength   = 31,
    parameter int unsigned DataLength = 31
) ();
    logic                  commit0_valid;
    logic                  commit1_valid;
    logic [RdLength:0]     rd0;
    logic [RdLength:0]     rd1;
    logic [PcLength:0]     pc0;
    logic [PcLength:0]     pc1;
    logic [DataLength:0]   data0;
    logic [DataLength:0]   data1;
    logic                  is_exception_from_rob;
    logic                  stall_to_rob;
    logic                  is_commit_to_rf;
    logic [RdLength:0]     rd_to_rf;
    logic [PcLength:0]     pc_to_rf;
    logic [DataLength:0]   data_to_rf;
    logic                  is_exception_to_rf;
    logic [RdLength:0]     rs1_from_decoder;
    logic [RdLength:0]     rs2_from_decoder;
    logic                  hit1;
    logic                  hit2;
    logic [DataLength:0]   bypass1;
    logic [DataLength:0]   bypass2;
    logic                  decoder_hold;

    modport master (
        output commit0_valid, commit1_valid, rd0, rd1, pc0, pc1, data0, data1,
               is_exception_from_rob, rs1_from_decoder, rs2_from_decoder,
        input  stall_to_rob, is_commit_to_rf, rd_to_rf, pc_to_rf, data_to_rf,
               is_exception_to_rf, hit1, hit2, bypass1, bypass2, decoder_hold
    );

    modport slave (
        input  commit0_valid, commit1_valid, rd0, rd1, pc0, pc1, data0, data1,
               is_exception_from_rob, rs1_from_decoder, rs2_from_decoder,
        output stall_to_rob, is_commit_to_rf, rd_to_rf, pc_to_rf, data_to_rf,
               is_exception_to_rf, hit1, hit2, bypass1, bypass2, decoder_hold
    );
endinterface

// File: rtl/rf_commit_sched.sv
// Commit-side scheduler for the register file's single write port.
// Buffers up to two in-order commits per cycle, drains one per cycle, and
// orders exception flushes behind all older writes.
// Optional feature macro: RF_COMMIT_BYPASS_EN (in-flight bypass search).
module rf_commit_sched #(
    parameter int unsigned QueueDepth = 4,
    parameter int unsigned RdLength   = 4,
    parameter int unsigned PcLength   = 31,
    parameter int unsigned DataLength = 31
) (
    input logic              clk,
    input logic              rst,
    rf_commit_sched_if.slave bus
);
    localparam int unsigned PtrW = $clog2(QueueDepth);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr1;
    logic [CntW-1:0]     count_q, count_d;
    logic [RdLength:0]   fifo_rd_q   [QueueDepth];
    logic [PcLength:0]   fifo_pc_q   [QueueDepth];
    logic [DataLength:0] fifo_data_q [QueueDepth];
    logic                accept, push0, push1, pop;
    logic                stall_q, stall_d, commit_q, exc_q, exc_d;
    logic [RdLength:0]   rd_out_q;
    logic [PcLength:0]   pc_out_q;
    logic [DataLength:0] data_out_q;

    // Push/pop decisions, occupancy and pointer advance
    always_comb begin
        accept   = (state_q == StRun) && !stall_q;
        push0    = accept && bus.commit0_valid;
        push1    = accept && bus.commit1_valid;
        pop      = (count_q != '0);
        count_d  = count_q + CntW'(push0) + CntW'(push1) - CntW'(pop);
        // A lone slot1 commit lands in the first free slot
        wr_ptr1  = wr_ptr_q + PtrW'(push0);
        wr_ptr_d = wr_ptr_q + PtrW'(push0) + PtrW'(push1);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
    end

    // Next state, flush pulse and stall; flush rides with the last drained write
    always_comb begin
        state_d = state_q;
        exc_d   = 1'b0;
        case (state_q)
            StRun: begin
                if (bus.is_exception_from_rob) state_d = StDrain;
            end
            StDrain: begin
                if (count_q <= CntW'(1)) begin
                    exc_d   = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
        // Keeps room for two pushes at the next edge
        stall_d = (count_d > CntW'(QueueDepth - 2)) || (state_d != StRun);
    end

    // Control state and output stage
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StRun;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            stall_q    <= 1'b0;
            commit_q   <= 1'b0;
            exc_q      <= 1'b0;
            rd_out_q   <= '0;
            pc_out_q   <= '0;
            data_out_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            stall_q  <= stall_d;
            commit_q <= pop;
            exc_q    <= exc_d;
            if (pop) begin
                rd_out_q   <= fifo_rd_q[rd_ptr_q];
                pc_out_q   <= fifo_pc_q[rd_ptr_q];
                data_out_q <= fifo_data_q[rd_ptr_q];
            end
        end
    end

    // FIFO storage; stale contents are harmless since count gates every read
    always_ff @(posedge clk) begin
        if (push0) begin
            fifo_rd_q[wr_ptr_q]   <= bus.rd0;
            fifo_pc_q[wr_ptr_q]   <= bus.pc0;
            fifo_data_q[wr_ptr_q] <= bus.data0;
        end
        if (push1) begin
            fifo_rd_q[wr_ptr1]   <= bus.rd1;
            fifo_pc_q[wr_ptr1]   <= bus.pc1;
            fifo_data_q[wr_ptr1] <= bus.data1;
        end
    end

`ifdef RF_COMMIT_BYPASS_EN
    // Bypass search, oldest to newest so the newest match wins
    always_comb begin
        bus.hit1    = 1'b0;
        bus.hit2    = 1'b0;
        bus.bypass1 = '0;
        bus.bypass2 = '0;
        if (commit_q && rd_out_q == bus.rs1_from_decoder) begin
            bus.hit1    = 1'b1;
            bus.bypass1 = data_out_q;
        end
        if (commit_q && rd_out_q == bus.rs2_from_decoder) begin
            bus.hit2    = 1'b1;
            bus.bypass2 = data_out_q;
        end
        for (int i = 0; i < QueueDepth; i++) begin
            if (CntW'(i) < count_q) begin
                if (fifo_rd_q[rd_ptr_q + PtrW'(i)] == bus.rs1_from_decoder) begin
                    bus.hit1    = 1'b1;
                    bus.bypass1 = fifo_data_q[rd_ptr_q + PtrW'(i)];
                end
                if (fifo_rd_q[rd_ptr_q + PtrW'(i)] == bus.rs2_from_decoder) begin
                    bus.hit2    = 1'b1;
                    bus.bypass2 = fifo_data_q[rd_ptr_q + PtrW'(i)];
                end
            end
        end
        // x0 is never a real producer
        if (bus.rs1_from_decoder == '0) begin
            bus.hit1    = 1'b0;
            bus.bypass1 = '0;
        end
        if (bus.rs2_from_decoder == '0) begin
            bus.hit2    = 1'b0;
            bus.bypass2 = '0;
        end
    end

    // Decoder hold during flush sequencing
    always_comb begin
        bus.decoder_hold = (state_q == StDrain) || exc_q;
    end
`else
    logic unused_rs;
    assign unused_rs = ^{bus.rs1_from_decoder, bus.rs2_from_decoder};

    // No bypass: decoder waits until nothing is in flight
    always_comb begin
        bus.hit1         = 1'b0;
        bus.hit2         = 1'b0;
        bus.bypass1      = '0;
        bus.bypass2      = '0;
        bus.decoder_hold = (state_q == StDrain) || exc_q || (count_q != '0) || commit_q;
    end
`endif

    // Registered outputs to the ROB and register file
    always_comb begin
        bus.stall_to_rob       = stall_q;
        bus.is_commit_to_rf    = commit_q;
        bus.rd_to_rf           = rd_out_q;
        bus.pc_to_rf           = pc_out_q;
        bus.data_to_rf         = data_out_q;
        bus.is_exception_to_rf = exc_q;
    end
endmodule

// File: tb/tb_rf_commit_sched.sv
// Self-checking bench for rf_commit_sched (QueueDepth=4).
`timescale 1ns/1ps
module tb_rf_commit_sched;
    localparam int unsigned QD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rf_commit_sched_if #(.RdLength(4), .PcLength(31), .DataLength(31)) bus ();

    rf_commit_sched #(
        .QueueDepth(QD), .RdLength(4), .PcLength(31), .DataLength(31)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        c0, c1;
        logic [4:0]  rd0, rd1;
        logic [31:0] pc0, d0, pc1, d1;
        logic        exc, acc;
        logic        e_commit, e_stall, e_exc, e_hold;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] pc, data;
    } ent_t;

    ent_t sb[$];
    vec_t tbl[23];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t v(int c0, int rd0, int pc0, int d0, int c1, int rd1, int pc1,
                               int d1, int exc, int acc, int ec, int es, int ee, int eh);
        vec_t r;
        r.c0 = 1'(c0);   r.rd0 = 5'(rd0); r.pc0 = 32'(pc0); r.d0 = 32'(d0);
        r.c1 = 1'(c1);   r.rd1 = 5'(rd1); r.pc1 = 32'(pc1); r.d1 = 32'(d1);
        r.exc = 1'(exc); r.acc = 1'(acc);
        r.e_commit = 1'(ec); r.e_stall = 1'(es); r.e_exc = 1'(ee); r.e_hold = 1'(eh);
        return r;
    endfunction

    function automatic vec_t idle(int ec, int es, int ee, int eh);
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ec, es, ee, eh);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, push accepted commits, check after the edge
    task automatic cycle(input string tag, input vec_t x);
        ent_t e;
        logic hold_exp;
        bus.commit0_valid = x.c0;  bus.rd0 = x.rd0; bus.pc0 = x.pc0; bus.data0 = x.d0;
        bus.commit1_valid = x.c1;  bus.rd1 = x.rd1; bus.pc1 = x.pc1; bus.data1 = x.d1;
        bus.is_exception_from_rob = x.exc;
        if (x.acc && x.c0) sb.push_back('{rd: x.rd0, pc: x.pc0, data: x.d0});
        if (x.acc && x.c1) sb.push_back('{rd: x.rd1, pc: x.pc1, data: x.d1});
        @(posedge clk);
        #1;
        chk({tag, " commit"}, 32'(bus.is_commit_to_rf), 32'(x.e_commit));
        if (bus.is_commit_to_rf) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s write: got unexpected rd=%0d want none", tag, bus.rd_to_rf);
            end else begin
                e = sb.pop_front();
                chk({tag, " rd"}, 32'(bus.rd_to_rf), 32'(e.rd));
                chk({tag, " pc"}, bus.pc_to_rf, e.pc);
                chk({tag, " data"}, bus.data_to_rf, e.data);
            end
        end
        chk({tag, " stall"}, 32'(bus.stall_to_rob), 32'(x.e_stall));
        chk({tag, " exc"}, 32'(bus.is_exception_to_rf), 32'(x.e_exc));
        hold_exp = x.e_hold;
`ifndef RF_COMMIT_BYPASS_EN
        hold_exp = hold_exp | (sb.size() != 0) | x.e_commit;
`endif
        chk({tag, " hold"}, 32'(bus.decoder_hold), 32'(hold_exp));
    endtask

    // Combinational bypass check on rs1 (rs2 set to an index never in flight)
    task automatic chk_byp(input string tag, input int rs1, input int h, input int b);
        logic        eh;
        logic [31:0] eb;
        bus.rs1_from_decoder = 5'(rs1);
        bus.rs2_from_decoder = 5'd31;
        #1;
`ifdef RF_COMMIT_BYPASS_EN
        eh = 1'(h);
        eb = 32'(b);
`else
        eh = 1'b0;
        eb = 32'd0;
`endif
        chk({tag, " hit1"}, 32'(bus.hit1), 32'(eh));
        chk({tag, " bypass1"}, bus.bypass1, eb);
        chk({tag, " hit2"}, 32'(bus.hit2), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"}, 32'(bus.stall_to_rob), 32'd0);
        chk({tag, " commit"}, 32'(bus.is_commit_to_rf), 32'd0);
        chk({tag, " rd"}, 32'(bus.rd_to_rf), 32'd0);
        chk({tag, " pc"}, bus.pc_to_rf, 32'd0);
        chk({tag, " data"}, bus.data_to_rf, 32'd0);
        chk({tag, " exc"}, 32'(bus.is_exception_to_rf), 32'd0);
        chk({tag, " hit"}, 32'({bus.hit1, bus.hit2}), 32'd0);
        chk({tag, " bypass"}, bus.bypass1 | bus.bypass2, 32'd0);
        chk({tag, " hold"}, 32'(bus.decoder_hold), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single commit, dual ordering, stall, exception with entries, exception empty
        tbl[0]  = v(1, 5, 'h100, 'hAA, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[1]  = idle(1, 0, 0, 0);
        tbl[2]  = idle(0, 0, 0, 0);
        tbl[3]  = v(1, 3, 'h200, 1, 1, 3, 'h204, 2, 0, 1, 0, 0, 0, 0);
        tbl[4]  = idle(1, 0, 0, 0);
        tbl[5]  = idle(1, 0, 0, 0);
        tbl[6]  = idle(0, 0, 0, 0);
        tbl[7]  = v(1, 7, 'h300, 'h10, 1, 8, 'h304, 'h11, 0, 1, 0, 0, 0, 0);
        tbl[8]  = v(1, 9, 'h308, 'h12, 1, 10, 'h30c, 'h13, 0, 1, 1, 1, 0, 0);
        tbl[9]  = v(1, 11, 'h310, 'h14, 1, 12, 'h314, 'h15, 0, 0, 1, 0, 0, 0);
        tbl[10] = v(1, 13, 'h318, 'h16, 1, 14, 'h31c, 'h17, 0, 1, 1, 1, 0, 0);
        tbl[11] = v(1, 15, 'h320, 'h18, 1, 16, 'h324, 'h19, 0, 0, 1, 0, 0, 0);
        tbl[12] = idle(1, 0, 0, 0);
        tbl[13] = idle(1, 0, 0, 0);
        tbl[14] = idle(0, 0, 0, 0);
        tbl[15] = v(1, 1, 'h400, 'h20, 1, 2, 'h404, 'h21, 0, 1, 0, 0, 0, 0);
        tbl[16] = v(1, 4, 'h408, 'h22, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1);
        tbl[17] = v(1, 17, 'h40c, 'h23, 1, 18, 'h410, 'h24, 0, 0, 1, 1, 0, 1);
        tbl[18] = idle(1, 0, 1, 1);
        tbl[19] = idle(0, 0, 0, 0);
        tbl[20] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
        tbl[21] = idle(0, 0, 1, 1);
        tbl[22] = idle(0, 0, 0, 0);

        bus.commit0_valid = 1'b0; bus.commit1_valid = 1'b0;
        bus.rd0 = '0; bus.rd1 = '0; bus.pc0 = '0; bus.pc1 = '0;
        bus.data0 = '0; bus.data1 = '0; bus.is_exception_from_rob = 1'b0;
        bus.rs1_from_decoder = '0; bus.rs2_from_decoder = '0;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 23; i++) cycle($sformatf("row%0d", i), tbl[i]);

        // Dual commit to the same register: bypass returns the newest value
        cycle("byp0", v(1, 20, 'h500, 'h31, 1, 20, 'h504, 'h32, 0, 1, 0, 0, 0, 0));
        chk_byp("byp0", 20, 1, 'h32);
        cycle("byp1", idle(1, 0, 0, 0));
        chk_byp("byp1", 20, 1, 'h32);
        cycle("byp2", idle(1, 0, 0, 0));
        chk_byp("byp2", 20, 1, 'h32);
        cycle("byp3", idle(0, 0, 0, 0));
        chk_byp("byp3", 20, 0, 0);

        // Reset in the middle of DRAIN drops entries and the pending flush
        cycle("rd0", v(1, 6, 'h600, 'h41, 1, 6, 'h604, 'h42, 0, 1, 0, 0, 0, 0));
        cycle("rd1", v(1, 6, 'h608, 'h43, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1));
        bus.commit0_valid = 1'b0; bus.commit1_valid = 1'b0;
        bus.is_exception_from_rob = 1'b0;
        bus.rs1_from_decoder = 5'd6; bus.rs2_from_decoder = 5'd6;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_all_zero("rstdrain");
        sb.delete();
        cycle("post0", idle(0, 0, 0, 0));
        cycle("post1", idle(0, 0, 0, 0));

        // x0 commit is written out but never hits
        cycle("x0a", v(1, 0, 'h700, 'h55, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        chk_byp("x0a", 0, 0, 0);
        cycle("x0b", idle(1, 0, 0, 0));
        chk_byp("x0b", 0, 0, 0);
        cycle("r9a", v(1, 9, 'h704, 'h77, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        chk_byp("r9a", 9, 1, 'h77);
        cycle("r9b", idle(1, 0, 0, 0));
        cycle("r9c", idle(0, 0, 0, 0));

        chk("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
